// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA keystream generator and decryptor over an encrypted ROM, with an
// optional plaintext range check that aborts on the first rejected byte.
module rc4_prga_decrypt #(
  parameter int unsigned MSG_LEN     = 32,
  parameter int unsigned AW          = $clog2(MSG_LEN),
  parameter int unsigned RD_WAIT     = 1,
  parameter bit          CHECK_EN    = 1'b1,
  parameter logic [7:0]  CHAR_LO     = 8'h61,
  parameter logic [7:0]  CHAR_HI     = 8'h7A,
  parameter bit          ALLOW_SPACE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          finish_ack,
  output logic [7:0]    s_addr,
  output logic [7:0]    s_wdata,
  output logic          s_wren,
  input  logic [7:0]    s_rdata,
  output logic [AW-1:0] c_addr,
  input  logic [7:0]    c_rdata,
  output logic [AW-1:0] d_addr,
  output logic [7:0]    d_wdata,
  output logic          d_wren,
  output logic          busy,
  output logic          done,
  output logic          msg_valid,
  output logic [AW-1:0] bad_index
);

  localparam logic [1:0]    WAIT_LAST = 2'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
  localparam logic [AW-1:0] K_LAST    = AW'(MSG_LEN - 1);
  localparam bit            NO_WAIT   = (RD_WAIT == 0);

  typedef enum logic [4:0] {
    IDLE, START, PREP, INC_I, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, SWAP_I,
    WR_I, WR_J, RD_F, WAIT_F, CALC_D, WR_D, CHECK, DONE
  } state_t;

  state_t     state, state_next;
  logic [7:0] i, j, si, sj;
  logic [AW-1:0] k;
  logic [1:0] wcnt;
  logic       wait_end_c, byte_ok_c, last_c, abort_c;

  assign wait_end_c = (wcnt == WAIT_LAST);
  assign byte_ok_c  = ((d_wdata >= CHAR_LO) && (d_wdata <= CHAR_HI)) ||
                      (ALLOW_SPACE && (d_wdata == 8'h20));
  assign last_c     = (k == K_LAST);
  assign abort_c    = CHECK_EN && !byte_ok_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; each issue state skips its wait state when RD_WAIT is 0
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = START;
      START:   state_next = PREP;
      PREP:    state_next = INC_I;
      INC_I:   state_next = RD_I;
      RD_I:    state_next = NO_WAIT ? CALC_J : WAIT_I;
      WAIT_I:  if (wait_end_c) state_next = CALC_J;
      CALC_J:  state_next = RD_J;
      RD_J:    state_next = NO_WAIT ? SWAP_I : WAIT_J;
      WAIT_J:  if (wait_end_c) state_next = SWAP_I;
      SWAP_I:  state_next = WR_I;
      WR_I:    state_next = WR_J;
      WR_J:    state_next = RD_F;
      RD_F:    state_next = NO_WAIT ? CALC_D : WAIT_F;
      WAIT_F:  if (wait_end_c) state_next = CALC_D;
      CALC_D:  state_next = WR_D;
      WR_D:    state_next = CHECK;
      CHECK:   state_next = (abort_c || last_c) ? DONE : INC_I;
      DONE:    if (finish_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Wait-state counter, cleared whenever not waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 2'd0;
    end else if (state inside {WAIT_I, WAIT_J, WAIT_F}) begin
      wcnt <= wcnt + 2'd1;
    end else begin
      wcnt <= 2'd0;
    end
  end

  // Datapath and registered outputs; strobes decode the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= '0;
      si        <= 8'd0;
      sj        <= 8'd0;
      s_addr    <= 8'd0;
      s_wdata   <= 8'd0;
      s_wren    <= 1'b0;
      c_addr    <= '0;
      d_addr    <= '0;
      d_wdata   <= 8'd0;
      d_wren    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      msg_valid <= 1'b0;
      bad_index <= '0;
    end else begin
      s_wren <= (state_next == WR_I) || (state_next == WR_J);
      d_wren <= (state_next == WR_D);
      busy   <= !(state_next inside {IDLE, DONE});
      done   <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            i         <= 8'd0;
            j         <= 8'd0;
            k         <= '0;
            s_addr    <= 8'd0;
            c_addr    <= '0;
            d_addr    <= '0;
            bad_index <= '0;
            msg_valid <= 1'b1;
          end
        end
        INC_I:  i <= i + 8'd1;
        RD_I:   s_addr <= i;
        CALC_J: begin
          si <= s_rdata;
          j  <= j + s_rdata;
        end
        RD_J:   s_addr <= j;
        SWAP_I: begin
          sj      <= s_rdata;
          s_addr  <= i;
          s_wdata <= s_rdata;
        end
        WR_I: begin
          s_addr  <= j;
          s_wdata <= si;
        end
        RD_F: begin
          s_addr <= si + sj;
          c_addr <= k;
        end
        CALC_D: begin
          d_wdata <= s_rdata ^ c_rdata;
          d_addr  <= k;
        end
        CHECK: begin
          if (abort_c) begin
            msg_valid <= 1'b0;
            bad_index <= k;
          end else if (!last_c) begin
            k <= k + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt: four instances covering the range check,
// unchecked decryption, RD_WAIT 0/1/3 and a 256-byte message.
module tb_rc4_prga_decrypt;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] s_addr [4];
  logic [7:0] s_wdata [4];
  logic [7:0] s_rdata [4];
  logic [7:0] c_rdata [4];
  logic [7:0] d_wdata [4];
  logic       s_wren [4];
  logic       d_wren [4];
  logic       busy [4];
  logic       done [4];
  logic       msg_valid [4];
  logic       start [4];
  logic       fack [4];
  logic       load [4];
  logic [4:0] ca_s [3];
  logic [4:0] da_s [3];
  logic [4:0] bi_s [3];
  logic [7:0] ca_d, da_d, bi_d;
  logic [7:0] c_addr8 [4];
  logic [7:0] d_addr8 [4];
  logic [7:0] bad8 [4];

  logic [7:0] s_init [256];
  logic [7:0] s_mem [4][256];
  logic [7:0] c_mem [4][256];
  logic [7:0] d_mem [4][256];
  logic [7:0] s_pipe [4][3];
  logic [7:0] c_pipe [4][3];
  logic [7:0] ks [256];
  int d_cnt [4];
  int d_t0 [4];
  int d_t1 [4];
  int cyc;
  int n_checks = 0;
  int n_fail = 0;

  rc4_prga_decrypt #(.MSG_LEN(32), .RD_WAIT(1), .CHECK_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .finish_ack(fack[0]),
    .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wren(s_wren[0]), .s_rdata(s_rdata[0]),
    .c_addr(ca_s[0]), .c_rdata(c_rdata[0]), .d_addr(da_s[0]), .d_wdata(d_wdata[0]),
    .d_wren(d_wren[0]), .busy(busy[0]), .done(done[0]), .msg_valid(msg_valid[0]),
    .bad_index(bi_s[0]));

  rc4_prga_decrypt #(.MSG_LEN(32), .RD_WAIT(1), .CHECK_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .finish_ack(fack[1]),
    .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wren(s_wren[1]), .s_rdata(s_rdata[1]),
    .c_addr(ca_s[1]), .c_rdata(c_rdata[1]), .d_addr(da_s[1]), .d_wdata(d_wdata[1]),
    .d_wren(d_wren[1]), .busy(busy[1]), .done(done[1]), .msg_valid(msg_valid[1]),
    .bad_index(bi_s[1]));

  rc4_prga_decrypt #(.MSG_LEN(32), .RD_WAIT(3), .CHECK_EN(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .finish_ack(fack[2]),
    .s_addr(s_addr[2]), .s_wdata(s_wdata[2]), .s_wren(s_wren[2]), .s_rdata(s_rdata[2]),
    .c_addr(ca_s[2]), .c_rdata(c_rdata[2]), .d_addr(da_s[2]), .d_wdata(d_wdata[2]),
    .d_wren(d_wren[2]), .busy(busy[2]), .done(done[2]), .msg_valid(msg_valid[2]),
    .bad_index(bi_s[2]));

  rc4_prga_decrypt #(.MSG_LEN(256), .RD_WAIT(0), .CHECK_EN(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .finish_ack(fack[3]),
    .s_addr(s_addr[3]), .s_wdata(s_wdata[3]), .s_wren(s_wren[3]), .s_rdata(s_rdata[3]),
    .c_addr(ca_d), .c_rdata(c_rdata[3]), .d_addr(da_d), .d_wdata(d_wdata[3]),
    .d_wren(d_wren[3]), .busy(busy[3]), .done(done[3]), .msg_valid(msg_valid[3]),
    .bad_index(bi_d));

  assign c_addr8[0] = 8'(ca_s[0]);
  assign c_addr8[1] = 8'(ca_s[1]);
  assign c_addr8[2] = 8'(ca_s[2]);
  assign c_addr8[3] = ca_d;
  assign d_addr8[0] = 8'(da_s[0]);
  assign d_addr8[1] = 8'(da_s[1]);
  assign d_addr8[2] = 8'(da_s[2]);
  assign d_addr8[3] = da_d;
  assign bad8[0]    = 8'(bi_s[0]);
  assign bad8[1]    = 8'(bi_s[1]);
  assign bad8[2]    = 8'(bi_s[2]);
  assign bad8[3]    = bi_d;

  function automatic int lat(input int n);
    if (n == 2) return 3;
    if (n == 3) return 0;
    return 1;
  endfunction

  function automatic logic [7:0] pt(input int b);
    return 8'(8'h61 + (b % 26));
  endfunction

  function automatic logic [52:0] outs(input int n);
    return {s_addr[n], s_wdata[n], s_wren[n], c_addr8[n], d_addr8[n], d_wdata[n],
            d_wren[n], busy[n], done[n], msg_valid[n], bad8[n]};
  endfunction

  // Read ports with RD_WAIT-cycle latency
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      if (lat(n) == 0) begin
        s_rdata[n] = s_mem[n][s_addr[n]];
        c_rdata[n] = c_mem[n][c_addr8[n]];
      end else begin
        s_rdata[n] = s_mem[n][s_pipe[n][lat(n)-1]];
        c_rdata[n] = c_mem[n][c_pipe[n][lat(n)-1]];
      end
    end
  end

  // Memory writes, reload and D write bookkeeping
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int n = 0; n < 4; n++) begin
      s_pipe[n][0] <= s_addr[n];
      s_pipe[n][1] <= s_pipe[n][0];
      s_pipe[n][2] <= s_pipe[n][1];
      c_pipe[n][0] <= c_addr8[n];
      c_pipe[n][1] <= c_pipe[n][0];
      c_pipe[n][2] <= c_pipe[n][1];
      if (load[n]) begin
        for (int x = 0; x < 256; x++) begin
          s_mem[n][x] <= s_init[x];
          d_mem[n][x] <= 8'h00;
        end
        d_cnt[n] <= 0;
      end else begin
        if (s_wren[n]) s_mem[n][s_addr[n]] <= s_wdata[n];
        if (d_wren[n]) begin
          d_mem[n][d_addr8[n]] <= d_wdata[n];
          d_cnt[n] <= d_cnt[n] + 1;
          if (d_cnt[n] == 0) d_t0[n] <= cyc;
          if (d_cnt[n] == 1) d_t1[n] <= cyc;
        end
      end
    end
  end

  task automatic gen_ks();
    logic [7:0] s [256];
    logic [7:0] i, j, t, f;
    i = 8'd0;
    j = 8'd0;
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    for (int b = 0; b < 256; b++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i];
      s[i] = s[j];
      s[j] = t;
      f = s[i] + s[j];
      ks[b] = s[f];
    end
  endtask

  task automatic load_mem(input int n);
    @(negedge clk);
    load[n] = 1'b1;
    @(negedge clk);
    load[n] = 1'b0;
  endtask

  task automatic start_run(input int n, output int c0);
    @(negedge clk);
    start[n] = 1'b1;
    @(posedge clk);
    #1;
    start[n] = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int n, input int limit, output int t);
    bit hit;
    hit = 1'b0;
    t = -1;
    for (int e = 0; e < limit && !hit; e++) begin
      @(posedge clk);
      #1;
      if (done[n]) begin
        hit = 1'b1;
        t = cyc;
      end
    end
  endtask

  task automatic ack(input int n);
    @(negedge clk);
    fack[n] = 1'b1;
    @(negedge clk);
    fack[n] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (outs(n) !== 53'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %h want 0", n, outs(n));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_abort();
    int c0, t;
    load_mem(0);
    for (int b = 0; b < 256; b++) c_mem[0][b] = 8'h00;
    start_run(0, c0);
    wait_done(0, 1000, t);
    n_checks++;
    if (t < 0) begin n_fail++; $display("FAIL zero_done_timeout: got no done want done"); end
    n_checks++;
    if (d_mem[0][0] !== 8'h02) begin n_fail++; $display("FAIL zero_d0: got %h want 02", d_mem[0][0]); end
    n_checks++;
    if (d_cnt[0] != 1) begin n_fail++; $display("FAIL zero_dwren_count: got %0d want 1", d_cnt[0]); end
    n_checks++;
    if (msg_valid[0] !== 1'b0) begin n_fail++; $display("FAIL zero_msg_valid: got %b want 0", msg_valid[0]); end
    n_checks++;
    if (bad8[0] !== 8'd0) begin n_fail++; $display("FAIL zero_bad_index: got %0d want 0", bad8[0]); end
    ack(0);
  endtask

  task automatic test_plain();
    int c0, t, g, errs;
    load_mem(1);
    for (int b = 0; b < 256; b++) c_mem[1][b] = ks[b] ^ pt(b);
    start_run(1, c0);
    g = 0;
    while (d_cnt[1] < 2 && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    n_checks++;
    if (s_mem[1][2] !== 8'd3 || s_mem[1][3] !== 8'd2) begin
      n_fail++;
      $display("FAIL plain_swap_byte1: got S2=%0d S3=%0d want S2=3 S3=2", s_mem[1][2], s_mem[1][3]);
    end
    wait_done(1, 2000, t);
    n_checks++;
    if (t - c0 != 450) begin n_fail++; $display("FAIL plain_done_edge: got %0d want 450", t - c0); end
    n_checks++;
    if (d_cnt[1] != 32) begin n_fail++; $display("FAIL plain_dwren_count: got %0d want 32", d_cnt[1]); end
    errs = 0;
    for (int b = 0; b < 32; b++) if (d_mem[1][b] !== pt(b)) errs++;
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL plain_d_contents: got %0d bad bytes want 0", errs); end
    n_checks++;
    if ((d_mem[1][1] ^ c_mem[1][1]) !== 8'h05) begin
      n_fail++;
      $display("FAIL plain_ks1: got %h want 05", d_mem[1][1] ^ c_mem[1][1]);
    end
    n_checks++;
    if (d_t1[1] - d_t0[1] != 14) begin n_fail++; $display("FAIL plain_byte_cycles: got %0d want 14", d_t1[1] - d_t0[1]); end
    n_checks++;
    if (msg_valid[1] !== 1'b1) begin n_fail++; $display("FAIL plain_msg_valid: got %b want 1", msg_valid[1]); end
    ack(1);
  endtask

  task automatic test_abort_craft();
    int c0, t, held;
    logic [7:0] p;
    load_mem(0);
    for (int b = 0; b < 256; b++) begin
      p = pt(b);
      if (b == 5) p = 8'h20;
      if (b == 7) p = 8'h41;
      c_mem[0][b] = ks[b] ^ p;
    end
    start_run(0, c0);
    repeat (20) @(negedge clk);
    start[0] = 1'b1;
    fack[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    fack[0] = 1'b0;
    n_checks++;
    if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_while_busy: got busy=%b done=%b want busy=1 done=0", busy[0], done[0]);
    end
    wait_done(0, 1000, t);
    n_checks++;
    if (t < 0) begin n_fail++; $display("FAIL abort_done_timeout: got no done want done"); end
    n_checks++;
    if (d_cnt[0] != 8) begin n_fail++; $display("FAIL abort_dwren_count: got %0d want 8", d_cnt[0]); end
    n_checks++;
    if (bad8[0] !== 8'd7) begin n_fail++; $display("FAIL abort_bad_index: got %0d want 7", bad8[0]); end
    n_checks++;
    if (msg_valid[0] !== 1'b0) begin n_fail++; $display("FAIL abort_msg_valid: got %b want 0", msg_valid[0]); end
    n_checks++;
    if (d_mem[0][5] !== 8'h20 || d_mem[0][7] !== 8'h41) begin
      n_fail++;
      $display("FAIL abort_d5_d7: got %h %h want 20 41", d_mem[0][5], d_mem[0][7]);
    end
    held = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (done[0] === 1'b1 && busy[0] === 1'b0 && msg_valid[0] === 1'b0 && bad8[0] === 8'd7) held++;
    end
    n_checks++;
    if (held != 100) begin n_fail++; $display("FAIL done_hold: got %0d stable cycles want 100", held); end
    ack(0);
    @(posedge clk);
    #1;
    n_checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_to_idle: got done=%b busy=%b want 0 0", done[0], busy[0]);
    end
  endtask

  task automatic test_rd_wait3();
    int c0, t, errs;
    load_mem(2);
    for (int b = 0; b < 256; b++) c_mem[2][b] = ks[b] ^ pt(b);
    start_run(2, c0);
    wait_done(2, 3000, t);
    n_checks++;
    if (t - c0 != 642) begin n_fail++; $display("FAIL w3_done_edge: got %0d want 642", t - c0); end
    errs = 0;
    for (int b = 0; b < 32; b++) if (d_mem[2][b] !== pt(b)) errs++;
    n_checks++;
    if (errs != 0 || d_cnt[2] != 32) begin
      n_fail++;
      $display("FAIL w3_d_contents: got %0d bad bytes, %0d writes want 0, 32", errs, d_cnt[2]);
    end
    n_checks++;
    if (d_t1[2] - d_t0[2] != 20) begin n_fail++; $display("FAIL w3_byte_cycles: got %0d want 20", d_t1[2] - d_t0[2]); end
    ack(2);
  endtask

  task automatic test_len256();
    int c0, t, errs;
    load_mem(3);
    for (int b = 0; b < 256; b++) c_mem[3][b] = ks[b] ^ pt(b);
    start_run(3, c0);
    wait_done(3, 6000, t);
    n_checks++;
    if (t - c0 != 2818) begin n_fail++; $display("FAIL len256_done_edge: got %0d want 2818", t - c0); end
    n_checks++;
    if (d_cnt[3] != 256) begin n_fail++; $display("FAIL len256_dwren_count: got %0d want 256", d_cnt[3]); end
    errs = 0;
    for (int b = 0; b < 256; b++) if (d_mem[3][b] !== pt(b)) errs++;
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL len256_d_contents: got %0d bad bytes want 0", errs); end
    n_checks++;
    if (d_mem[3][255] !== pt(255)) begin n_fail++; $display("FAIL len256_last_byte: got %h want %h", d_mem[3][255], pt(255)); end
    n_checks++;
    if (msg_valid[3] !== 1'b1) begin n_fail++; $display("FAIL len256_msg_valid: got %b want 1", msg_valid[3]); end
    n_checks++;
    if (d_t1[3] - d_t0[3] != 11) begin n_fail++; $display("FAIL w0_byte_cycles: got %0d want 11", d_t1[3] - d_t0[3]); end
    ack(3);
  endtask

  task automatic test_mid_reset();
    int c0, g;
    load_mem(0);
    for (int b = 0; b < 256; b++) c_mem[0][b] = ks[b] ^ pt(b);
    start_run(0, c0);
    g = 0;
    while (s_wren[0] !== 1'b1 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    n_checks++;
    if (s_wren[0] !== 1'b1) begin n_fail++; $display("FAIL mid_reset_reach_wr_i: got %b want 1", s_wren[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs(0) !== 53'd0) begin n_fail++; $display("FAIL mid_reset_async_outputs: got %h want 0", outs(0)); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: got busy=%b done=%b want 0 0", busy[0], done[0]);
    end
  endtask

  initial begin
    for (int n = 0; n < 4; n++) begin
      start[n] = 1'b0;
      fack[n]  = 1'b0;
      load[n]  = 1'b0;
    end
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    gen_ks();
    test_reset();
    test_zero_abort();
    test_plain();
    test_abort_craft();
    test_rd_wait3();
    test_len256();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
